// File: rtl/s2p_pkg.sv
// Shared definitions for the SPI serial-to-parallel front end.
//   DEF_WIDTH / DEF_DEPTH / DEF_TIMEOUT : default word width, FIFO depth, idle timeout
//   frame_state_t                      : frame tracker state
//   s2p_entry_t                        : FIFO entry layout at the default width
package s2p_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 4;

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_ACTIVE = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic                 sof;
    logic [DEF_WIDTH-1:0] data;
  } s2p_entry_t;

endpackage

// File: rtl/s2p_word_fifo.sv
// Synchronous FIFO holding completed words.
//   iclk, rst  : clock, synchronous active-high reset
//   push/wdata : write request; dropped when full unless a pop happens the same cycle
//   pop/rdata  : read request (ignored when empty) and head entry
//   full/empty : occupancy flags
//   count      : number of stored entries
module s2p_word_fifo #(
  parameter int unsigned DW    = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       iclk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a full FIFO can still accept a push.
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the head is qualified by empty downstream.
  always_ff @(posedge iclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/s2p_deserializer.sv
// Oversampling SPI deserializer: assembles WIDTH-bit words, ends frames on an
// idle timeout and buffers words in a FIFO behind a valid/ready handshake.
//   iclk, rst            : internal clock, synchronous active-high reset
//   spi_clk, serial_in   : asynchronous SPI pins, sampled on iclk
//   m_data/m_sof/m_valid : FIFO head word, first-of-frame flag, non-empty
//   m_ready              : consumer accept
//   frame_done/frag_err  : frame end pulse / frame ended with a partial word
//   overflow             : completed word dropped because the FIFO was full
//   fill                 : FIFO occupancy
module s2p_deserializer
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                       iclk,
  input  logic                       rst,
  input  logic                       spi_clk,
  input  logic                       serial_in,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_sof,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       frame_done,
  output logic                       frag_err,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned BW = $clog2(WIDTH+1);
  localparam int unsigned IW = $clog2(TIMEOUT+1);
  localparam int unsigned FW = $clog2(DEPTH+1);

  typedef struct packed {
    logic             sof;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic         clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic         edge_q, bit_q;
  logic         edge_nxt_c;
  frame_state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic         sof_pend_q, sof_pend_d;
  logic         push_c, timeout_c, frag_c, pop_c;
  entry_t       push_entry, head_entry;
  logic         fifo_full, fifo_empty;
  logic [FW-1:0] fifo_count;

  // Two-flop synchronisers on both pins, then a registered rising-edge strobe
  // with the data bit captured alongside it.
  always_ff @(posedge iclk) begin
    if (rst) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
      edge_q   <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      clk_s1   <= spi_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= serial_in;
      dat_s2   <= dat_s1;
      edge_q   <= edge_nxt_c;
      bit_q    <= dat_s2;
    end
  end

  // Edge that edge_q will carry next cycle; lets the timeout pulse be registered
  // yet still land exactly TIMEOUT cycles after the last edge.
  assign edge_nxt_c = clk_s2 & ~clk_prev;

  // Frame tracker, shifter and counters.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q    <= FR_IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      idle_q     <= '0;
      sof_pend_q <= 1'b1;
      frame_done <= 1'b0;
      frag_err   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_q     <= idle_d;
      sof_pend_q <= sof_pend_d;
      frame_done <= timeout_c;
      frag_err   <= frag_c;
      overflow   <= push_c & fifo_full & ~pop_c;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    idle_d     = idle_q;
    sof_pend_d = sof_pend_q;
    push_c     = 1'b0;
    timeout_c  = 1'b0;
    frag_c     = 1'b0;

    if (edge_q) begin
      if (MSB_FIRST != 0) sh_d = {sh_q[WIDTH-2:0], bit_q};
      else                sh_d = {bit_q, sh_q[WIDTH-1:1]};
      state_d = FR_ACTIVE;
      idle_d  = '0;
      if (bit_cnt_q == BW'(WIDTH-1)) begin
        push_c     = 1'b1;
        bit_cnt_d  = '0;
        sof_pend_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else if (state_q == FR_ACTIVE) begin
      // idle_q holds the quiet cycles already seen; this cycle plus the
      // next (known edge-free) one complete the TIMEOUT-long gap.
      if (!edge_nxt_c && idle_q == IW'(TIMEOUT-2)) begin
        timeout_c  = 1'b1;
        frag_c     = (bit_cnt_q != '0);
        state_d    = FR_IDLE;
        bit_cnt_d  = '0;
        idle_d     = '0;
        sof_pend_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end

    push_entry.sof  = sof_pend_q;
    push_entry.data = sh_d;
  end

  assign pop_c = m_valid & m_ready;

  s2p_word_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iclk  (iclk),
    .rst   (rst),
    .push  (push_c),
    .wdata (push_entry),
    .pop   (pop_c),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is forced to zero when empty so stale storage never shows.
  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? head_entry.data : '0;
  assign m_sof   = m_valid & head_entry.sof;
  assign fill    = fifo_count;

endmodule

// File: doc/s2p_deserializer.md
# s2p_deserializer

Parametrised serial-to-parallel front end, replacing the fixed 8-bit s2p chain. Oversamples the SPI clock and data on the internal clock, assembles WIDTH-bit words, detects end of frame by an idle timeout, and buffers completed words in a DEPTH-entry FIFO behind a valid/ready handshake. Sits between the chip SPI pins and the register/command decoder.

## Interface
- WIDTH, 8: bits per word, ≥2.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- TIMEOUT, 4: consecutive iclk cycles with no SPI rising edge that end a frame, ≥2.
- MSB_FIRST, 1: 1 = first received bit lands in data[WIDTH-1]; 0 = first bit in data[0].
- Ports:
- iclk  in  1  internal clock, the only clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- spi_clk  in  1  SPI clock, asynchronous to iclk, sampled as data.
- serial_in  in  1  SPI data, asynchronous, sampled as data.
- m_data  out  WIDTH  word at FIFO head.
- m_sof  out  1  head word is the first word of its frame.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts head when m_valid & m_ready.
- frame_done  out  1  one-cycle pulse at frame end.
- frag_err  out  1  one-cycle pulse: frame ended with partial word (discarded).
- overflow  out  1  one-cycle pulse: completed word dropped, FIFO full.
- fill  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- spi_clk and serial_in each pass a 2-flop synchroniser (same depth, so aligned). Rising edge = synced spi_clk 1 now, 0 previous cycle; exactly one edge per SPI rising edge. iclk ≥ 4× spi_clk required.
- On edge: synced serial_in shifted into assembly register per MSB_FIRST; bit_cnt increments; frame becomes active; idle counter clears.
- bit_cnt reaching WIDTH: word pushed to FIFO with sof = 1 if first word since frame start; bit_cnt to 0.
- Frame active, no edge: idle counter increments. At TIMEOUT: frame_done pulses; if bit_cnt ≠ 0 frag_err pulses same cycle and partial bits discarded; bit_cnt, idle counter clear; frame inactive; next word gets sof = 1.
- Edge and timeout never coincide: an edge clears the idle counter, edge wins.
- Push while full without simultaneous pop: word dropped, overflow pulses, FIFO unchanged. Push and pop same cycle while full: both occur, no overflow, fill unchanged.
- Pop when m_valid & m_ready; m_ready ignored when empty.
- m_data/m_sof held stable while m_valid & !m_ready.

## Timing
- Reset: all outputs 0, FIFO empty, fill 0, bit_cnt 0, frame inactive, synchronisers cleared. Reset mid-frame discards all partial and buffered data, no pulses.
- Pin to edge detect: 3 iclk cycles (2 sync + edge register).
- Final-bit edge cycle E: FIFO written end of E; m_valid, fill updated at E+1. No empty-FIFO bypass.
- Pop at cycle P: next head (or m_valid=0) at P+1.
- frame_done at cycle E_last + TIMEOUT, E_last = cycle of last edge.
- Counters sized: bit_cnt $clog2(WIDTH+1), idle $clog2(TIMEOUT+1); no wrap within a frame.

## Structure
- Package s2p_pkg: default WIDTH/DEPTH/TIMEOUT constants, typedef for FIFO entry struct {sof, data}.
- Sub-module s2p_word_fifo: synchronous FIFO, push/pop/full/empty/count, pointer wrap at DEPTH, simultaneous push/pop when full.
- Top holds synchronisers, edge detect, shifter, bit/idle counters, frame state.

## Test plan
- Defaults, MSB_FIRST=1, send 0xA5 then idle, m_ready=1 -> one word 0xA5 with m_sof=1, frame_done 4 cycles after last edge, no frag_err.
- Frame of 3 bytes 0x01,0x02,0x03, m_ready=0 -> fill=3, head 0x01 sof=1, then 0x02/0x03 sof=0 on pop; frame_done once.
- 5 bits then idle -> frag_err and frame_done same cycle, no push; next byte 0x3C has sof=1.
- 5 bytes, m_ready=0, DEPTH=4 -> 5th byte dropped with overflow pulse; repeat with pop in 5th push cycle -> no overflow, fill stays 4.
- MSB_FIRST=0, WIDTH=16, bits 1,0,0…0 -> m_data=0x0001; reset asserted mid-word -> all outputs 0, next frame clean.
